// File: rtl/noc_params_pkg.sv
// Shared definitions for the NoC traffic engine: FSM states, defaults and the
// status encoding presented on state_o.
package noc_params_pkg;

    localparam int unsigned DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRun      = 3'd1,
        StDrain    = 3'd2,
        StDone     = 3'd3,
        StDeadlock = 3'd4
    } state_e;

    localparam logic [2:0] STATUS_IDLE     = 3'd0;
    localparam logic [2:0] STATUS_RUN      = 3'd1;
    localparam logic [2:0] STATUS_DRAIN    = 3'd2;
    localparam logic [2:0] STATUS_DONE     = 3'd3;
    localparam logic [2:0] STATUS_DEADLOCK = 3'd4;

    function automatic logic [2:0] state_status(input state_e s);
        case (s)
            StRun:      return STATUS_RUN;
            StDrain:    return STATUS_DRAIN;
            StDone:     return STATUS_DONE;
            StDeadlock: return STATUS_DEADLOCK;
            default:    return STATUS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/progress_watchdog.sv
// Windowed progress monitor: trips when a progress count has not moved over a
// full window while the producer is still stalled.
module progress_watchdog #(
    parameter int unsigned WIN = 10000,
    parameter int unsigned W   = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] progress,
    input  logic         stalled,
    output logic         trip
);

    localparam int unsigned CW = (WIN > 1) ? $clog2(WIN) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sample_q, sample_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(WIN - 1));

    always_comb begin
        cnt_d    = '0;
        sample_d = sample_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            if (cnt_q == '0) begin
                sample_d = progress;
            end
        end
    end

    assign trip = en && wrap && stalled && (progress == sample_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            sample_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: rtl/noc_traffic_engine.sv
// Packet-memory driven traffic generator for one injection channel plus
// counters/XOR signatures on the ejection channels, with drain and deadlock detection.
module noc_traffic_engine
    import noc_params_pkg::*;
#(
    parameter  int unsigned DW        = DW_DEFAULT,
    parameter  int unsigned DEPTH     = 1024,
    parameter  int unsigned NUM_SINK  = 2,
    parameter  int unsigned WIN       = 10000,
    parameter  int unsigned DRAIN_CYC = 256,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic                   start,
    input  logic                   loop,
    input  logic [31:0]            num_flits,
    input  logic                   stop,
    output logic [DW-1:0]          data_o_src,
    output logic                   valid_o_src,
    input  logic                   ready_i_src,
    input  logic [NUM_SINK*DW-1:0] data_i_sink,
    input  logic [NUM_SINK-1:0]    valid_i_sink,
    output logic [NUM_SINK-1:0]    ready_o_sink,
    output logic [2:0]             state_o,
    output logic [31:0]            sent_cnt,
    output logic [NUM_SINK*32-1:0] rcv_cnt,
    output logic [NUM_SINK*DW-1:0] rcv_xor,
    output logic                   deadlock
);

    localparam int unsigned IW = $clog2(DRAIN_CYC + 1);

    state_e                           state_q, state_d;
    logic [AW-1:0]                    addr_q, addr_d;
    logic [31:0]                      sent_q, sent_d;
    logic [31:0]                      num_q, num_d;
    logic                             valid_q, valid_d;
    logic                             rdy_q, rdy_d;
    logic                             loop_q, loop_d;
    logic                             stop_q, stop_d;
    logic                             dl_q, dl_d;
    logic [IW-1:0]                    idle_q, idle_d;
    logic [NUM_SINK-1:0][31:0]        rcv_q, rcv_d;
    logic [NUM_SINK-1:0][DW-1:0]      xor_q, xor_d;

    logic [DW-1:0]       mem_q [DEPTH];
    logic                src_acc;
    logic [NUM_SINK-1:0] sink_acc;
    logic                stop_pend;
    logic                wd_trip;

    // Contents survive reset; only loadable while idle so the read stays stable in RUN.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    progress_watchdog #(
        .WIN (WIN),
        .W   (32)
    ) u_watchdog (
        .clk      (clk),
        .rstn     (rstn),
        .en       (state_q == StRun),
        .progress (sent_q),
        .stalled  (valid_q),
        .trip     (wd_trip)
    );

    assign src_acc  = valid_q & ready_i_src;
    assign sink_acc = valid_i_sink & {NUM_SINK{rdy_q}};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sent_d    = sent_q;
        num_d     = num_q;
        valid_d   = valid_q;
        loop_d    = loop_q;
        stop_d    = stop_q;
        dl_d      = dl_q;
        idle_d    = idle_q;
        rcv_d     = rcv_q;
        xor_d     = xor_q;
        stop_pend = stop_q | stop;

        for (int i = 0; i < NUM_SINK; i++) begin
            if (sink_acc[i]) begin
                if (rcv_q[i] != '1) begin
                    rcv_d[i] = rcv_q[i] + 32'd1;
                end
                xor_d[i] = xor_q[i] ^ data_i_sink[i*DW +: DW];
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = '0;
                    sent_d  = '0;
                    rcv_d   = '0;
                    xor_d   = '0;
                    loop_d  = loop;
                    num_d   = num_flits;
                    stop_d  = 1'b0;
                    valid_d = loop | (num_flits != '0);
                end
            end
            StRun: begin
                if (wd_trip) begin
                    state_d = StDeadlock;
                    valid_d = 1'b0;
                    dl_d    = 1'b1;
                end else begin
                    if (src_acc) begin
                        addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                        sent_d = sent_q + 32'd1;
                    end
                    if (!loop_q) begin
                        if (sent_d == num_q) begin
                            state_d = StDrain;
                            valid_d = 1'b0;
                            idle_d  = '0;
                        end
                    end else if (stop_pend && (src_acc || !valid_q)) begin
                        state_d = StDrain;
                        valid_d = 1'b0;
                        idle_d  = '0;
                        stop_d  = 1'b0;
                    end else begin
                        stop_d = stop_pend;
                    end
                end
            end
            StDrain: begin
                idle_d = (|sink_acc) ? '0 : idle_q + IW'(1);
                if (idle_d == IW'(DRAIN_CYC)) begin
                    state_d = StDone;
                end
            end
            StDeadlock: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        rdy_d = (state_d == StRun) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            sent_q  <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
            loop_q  <= 1'b0;
            stop_q  <= 1'b0;
            dl_q    <= 1'b0;
            idle_q  <= '0;
            rcv_q   <= '0;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sent_q  <= sent_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            loop_q  <= loop_d;
            stop_q  <= stop_d;
            dl_q    <= dl_d;
            idle_q  <= idle_d;
            rcv_q   <= rcv_d;
            xor_q   <= xor_d;
        end
    end

    assign data_o_src   = mem_q[addr_q];
    assign valid_o_src  = valid_q;
    assign ready_o_sink = {NUM_SINK{rdy_q}};
    assign state_o      = state_status(state_q);
    assign sent_cnt     = sent_q;
    assign rcv_cnt      = rcv_q;
    assign rcv_xor      = xor_q;
    assign deadlock     = dl_q;

endmodule

// File: tb/tb_noc_traffic_engine.sv
// Randomized bench for noc_traffic_engine with a cycle-level behavioural model
// and a few directed scenarios pinned by literal expectations.
module tb_noc_traffic_engine;

    localparam int unsigned DW        = 16;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned NUM_SINK  = 2;
    localparam int unsigned WIN       = 64;
    localparam int unsigned DRAIN_CYC = 8;
    localparam int unsigned AW        = 4;

    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3, S_DL = 4;

    logic                   clk;
    logic                   rstn;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [DW-1:0]          wr_data;
    logic                   start, loop, stop;
    logic [31:0]            num_flits;
    logic [DW-1:0]          data_o_src;
    logic                   valid_o_src;
    logic                   ready_i_src;
    logic [NUM_SINK*DW-1:0] data_i_sink;
    logic [NUM_SINK-1:0]    valid_i_sink;
    logic [NUM_SINK-1:0]    ready_o_sink;
    logic [2:0]             state_o;
    logic [31:0]            sent_cnt;
    logic [NUM_SINK*32-1:0] rcv_cnt;
    logic [NUM_SINK*DW-1:0] rcv_xor;
    logic                   deadlock;

    noc_traffic_engine #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .NUM_SINK  (NUM_SINK),
        .WIN       (WIN),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .loop         (loop),
        .num_flits    (num_flits),
        .stop         (stop),
        .data_o_src   (data_o_src),
        .valid_o_src  (valid_o_src),
        .ready_i_src  (ready_i_src),
        .data_i_sink  (data_i_sink),
        .valid_i_sink (valid_i_sink),
        .ready_o_sink (ready_o_sink),
        .state_o      (state_o),
        .sent_cnt     (sent_cnt),
        .rcv_cnt      (rcv_cnt),
        .rcv_xor      (rcv_xor),
        .deadlock     (deadlock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_state, m_addr, m_run_cyc, m_idle;
    logic          m_valid, m_rdy, m_loop, m_stop, m_dl;
    logic [31:0]   m_sent, m_num, m_sample;
    logic [31:0]   m_rcv [NUM_SINK];
    logic [DW-1:0] m_xor [NUM_SINK];

    task automatic model_reset();
        m_state = S_IDLE; m_addr = 0; m_run_cyc = 0; m_idle = 0;
        m_valid = 0; m_rdy = 0; m_loop = 0; m_stop = 0; m_dl = 0;
        m_sent = 0; m_num = 0; m_sample = 0;
        for (int i = 0; i < NUM_SINK; i++) begin
            m_rcv[i] = 0;
            m_xor[i] = 0;
        end
    endtask

    task automatic model_step();
        bit acc, any, trip;
        int ph;
        acc = m_valid && ready_i_src;
        any = 0;
        if (m_rdy) begin
            for (int i = 0; i < NUM_SINK; i++) begin
                if (valid_i_sink[i]) begin
                    any = 1;
                    if (m_rcv[i] != 32'hFFFF_FFFF) m_rcv[i] = m_rcv[i] + 1;
                    m_xor[i] = m_xor[i] ^ data_i_sink[i*DW +: DW];
                end
            end
        end
        case (m_state)
            S_IDLE, S_DONE: begin
                if (m_state == S_IDLE && wr_en) m_mem[wr_addr] = wr_data;
                if (start) begin
                    m_state = S_RUN; m_addr = 0; m_sent = 0; m_stop = 0; m_run_cyc = 0;
                    m_loop = loop; m_num = num_flits; m_rdy = 1;
                    m_valid = loop || (num_flits != 0);
                    for (int i = 0; i < NUM_SINK; i++) begin
                        m_rcv[i] = 0;
                        m_xor[i] = 0;
                    end
                end
            end
            S_RUN: begin
                ph   = m_run_cyc % WIN;
                trip = (ph == WIN - 1) && (m_sent == m_sample) && m_valid;
                if (ph == 0) m_sample = m_sent;
                m_run_cyc++;
                if (trip) begin
                    m_state = S_DL; m_valid = 0; m_rdy = 0; m_dl = 1;
                end else begin
                    if (acc) begin
                        m_addr = (m_addr + 1) % DEPTH;
                        m_sent = m_sent + 1;
                    end
                    if (!m_loop) begin
                        if (m_sent == m_num) begin
                            m_state = S_DRAIN; m_valid = 0; m_idle = 0;
                        end
                    end else if ((m_stop || stop) && (acc || !m_valid)) begin
                        m_state = S_DRAIN; m_valid = 0; m_idle = 0; m_stop = 0;
                    end else begin
                        m_stop = m_stop || stop;
                    end
                end
            end
            S_DRAIN: begin
                m_idle = any ? 0 : m_idle + 1;
                if (m_idle == DRAIN_CYC) begin
                    m_state = S_DONE; m_rdy = 0;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare + acceptance log ----------------
    logic [DW-1:0] acc_q [$];
    logic          pv, pr;
    logic [DW-1:0] pd;

    initial begin
        pv = 0; pr = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("state", 64'(state_o), 64'(m_state));
                chk("valid", 64'(valid_o_src), 64'(m_valid));
                if (m_valid) chk("data", 64'(data_o_src), 64'(m_mem[m_addr]));
                chk("sent", 64'(sent_cnt), 64'(m_sent));
                chk("rdy_sink", 64'(ready_o_sink), 64'({NUM_SINK{m_rdy}}));
                chk("deadlock", 64'(deadlock), 64'(m_dl));
                for (int i = 0; i < NUM_SINK; i++) begin
                    chk("rcv_cnt", 64'(rcv_cnt[i*32 +: 32]), 64'(m_rcv[i]));
                    chk("rcv_xor", 64'(rcv_xor[i*DW +: DW]), 64'(m_xor[i]));
                end
                if (pv && !pr && !deadlock) begin
                    chk("hold_valid", 64'(valid_o_src), 64'(1));
                    chk("hold_data", 64'(data_o_src), 64'(pd));
                end
                if (valid_o_src && ready_i_src) acc_q.push_back(data_o_src);
                pv = valid_o_src; pr = ready_i_src; pd = data_o_src;
            end else begin
                pv = 0;
            end
        end
    end

    // ---------------- channel drivers ----------------
    int rdy_mode  = 0;  // 0 low, 1 high, 2 toggle, 3 random
    int sink_mode = 0;  // 0 idle, 1 fixed A5/5A on both, 2 sparse random

    initial begin
        ready_i_src = 0; valid_i_sink = '0; data_i_sink = '0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ready_i_src = 1'b0;
                1:       ready_i_src = 1'b1;
                2:       ready_i_src = ~ready_i_src;
                default: ready_i_src = ($urandom_range(0, 1) == 1);
            endcase
            case (sink_mode)
                0: valid_i_sink = '0;
                1: begin
                    valid_i_sink = '1;
                    data_i_sink  = {16'h005A, 16'h00A5};
                end
                default: begin
                    for (int i = 0; i < NUM_SINK; i++) valid_i_sink[i] = ($urandom_range(0, 7) == 0);
                    data_i_sink = $urandom;
                end
            endcase
        end
    end

    // ---------------- directed / random scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1;
            wr_addr = AW'(i);
            wr_data = rnd ? DW'($urandom) : 16'h1000 + 16'(i);
            tick();
        end
        wr_en = 0;
    endtask

    task automatic kick(input bit lp, input int n);
        loop = lp; num_flits = n; start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_state(input int st, input int budget, input string name, output int dc);
        int n;
        n = 0; dc = 0;
        while (int'(state_o) != st && n < budget) begin
            tick();
            n++;
            if (state_o == 3'(S_DRAIN)) dc++;
        end
        chk(name, 64'(state_o), 64'(st));
    endtask

    task automatic do_reset(input string name);
        rstn = 0;
        #1;
        chk({name, "_rst_state"}, 64'(state_o), 64'(S_IDLE));
        chk({name, "_rst_valid"}, 64'(valid_o_src), 64'(0));
        chk({name, "_rst_sent"}, 64'(sent_cnt), 64'(0));
        chk({name, "_rst_rdy"}, 64'(ready_o_sink), 64'(0));
        chk({name, "_rst_dl"}, 64'(deadlock), 64'(0));
        tick();
        rstn = 1;
    endtask

    initial begin
        int dc, n, lp;
        rstn = 1; start = 0; loop = 0; stop = 0; num_flits = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        #2 rstn = 0;
        #2;
        chk("reset_state", 64'(state_o), 64'(S_IDLE));
        chk("reset_valid", 64'(valid_o_src), 64'(0));
        chk("reset_sent", 64'(sent_cnt), 64'(0));
        chk("reset_rdy", 64'(ready_o_sink), 64'(0));
        chk("reset_dl", 64'(deadlock), 64'(0));
        chk("reset_rcv", 64'(rcv_cnt), 64'(0));
        chk("reset_xor", 64'(rcv_xor), 64'(0));
        tick();
        rstn = 1;

        // 8-flit one-shot, always ready
        load_mem(0);
        rdy_mode = 1; acc_q.delete();
        kick(0, 8);
        wait_state(S_DONE, 200, "t1_done", dc);
        chk("t1_nacc", 64'(acc_q.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("t1_flit", 64'(acc_q[i]), 64'(16'h1000 + 16'(i)));
        chk("t1_sent", 64'(sent_cnt), 64'(8));
        chk("t1_drain_len", 64'(dc), 64'(DRAIN_CYC));

        // same with toggling ready, restarted from DONE
        rdy_mode = 2; acc_q.delete();
        kick(0, 8);
        wait_state(S_DONE, 200, "t2_done", dc);
        chk("t2_nacc", 64'(acc_q.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("t2_flit", 64'(acc_q[i]), 64'(16'h1000 + 16'(i)));
        chk("t2_sent", 64'(sent_cnt), 64'(8));

        // write outside IDLE is dropped
        wr_en = 1; wr_addr = '0; wr_data = 16'hDEAD;
        tick();
        wr_en = 0;
        rdy_mode = 1; acc_q.delete();
        kick(0, 1);
        wait_state(S_DONE, 100, "t3_done", dc);
        chk("t3_drop_write", 64'(acc_q[0]), 64'(16'h1000));

        // zero-length one-shot
        acc_q.delete();
        kick(0, 0);
        wait_state(S_DONE, 100, "t4_done", dc);
        chk("t4_nacc", 64'(acc_q.size()), 64'(0));
        chk("t4_sent", 64'(sent_cnt), 64'(0));

        // both sinks active together for three cycles
        kick(0, 2);
        sink_mode = 1;
        repeat (3) tick();
        sink_mode = 0;
        wait_state(S_DONE, 100, "t5_done", dc);
        chk("t5_rcv0", 64'(rcv_cnt[31:0]), 64'(3));
        chk("t5_rcv1", 64'(rcv_cnt[63:32]), 64'(3));
        chk("t5_xor0", 64'(rcv_xor[15:0]), 64'(16'h00A5));
        chk("t5_xor1", 64'(rcv_xor[31:16]), 64'(16'h005A));

        // loop mode, stop while a flit is pending
        acc_q.delete(); rdy_mode = 1;
        kick(1, 0);
        n = 0;
        while (acc_q.size() < 40 && n < 500) begin
            tick();
            n++;
        end
        rdy_mode = 0; stop = 1;
        tick();
        stop = 0; rdy_mode = 1;
        wait_state(S_DONE, 200, "t6_done", dc);
        chk("t6_sent", 64'(sent_cnt), 64'(41));
        chk("t6_nacc", 64'(acc_q.size()), 64'(41));
        chk("t6_wrap1", 64'(acc_q[16]), 64'(16'h1000));
        chk("t6_wrap2", 64'(acc_q[32]), 64'(16'h1000));
        chk("t6_last", 64'(acc_q[40]), 64'(16'h1008));

        // deadlock with ready held low
        rdy_mode = 0;
        kick(0, 8);
        n = 0;
        while (!deadlock && n < 2 * WIN) begin
            tick();
            n++;
        end
        chk("t7_deadlock", 64'(deadlock), 64'(1));
        chk("t7_state", 64'(state_o), 64'(S_DL));
        kick(0, 8);
        repeat (5) tick();
        chk("t7_sticky", 64'(state_o), 64'(S_DL));
        chk("t7_valid", 64'(valid_o_src), 64'(0));
        chk("t7_rdy", 64'(ready_o_sink), 64'(0));
        do_reset("t7");

        // reset mid-transfer, then restart from address 0
        rdy_mode = 1; acc_q.delete();
        kick(0, 8);
        n = 0;
        while (sent_cnt != 3 && n < 50) begin
            tick();
            n++;
        end
        chk("t8_at3", 64'(sent_cnt), 64'(3));
        do_reset("t8");
        acc_q.delete();
        kick(0, 8);
        wait_state(S_DONE, 200, "t8_done", dc);
        chk("t8_nacc", 64'(acc_q.size()), 64'(8));
        chk("t8_first", 64'(acc_q[0]), 64'(16'h1000));

        // randomized runs against the model
        for (int it = 0; it < 8; it++) begin
            do_reset("rnd");
            load_mem(1);
            rdy_mode = 3; sink_mode = 2;
            lp = $urandom_range(0, 1);
            kick(lp[0], $urandom_range(1, 30));
            if (lp == 1) begin
                repeat ($urandom_range(5, 60)) tick();
                stop = 1;
                tick();
                stop = 0;
            end
            wait_state(S_DONE, 3000, "rnd_done", dc);
            sink_mode = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_traffic_engine.md
NOC_TRAFFIC_ENGINE -- requirements
Module: noc_traffic_engine

Interface
REQ-001 Parameter DW, default 32: flit width in bits.
REQ-002 Parameter DEPTH, default 1024: packet memory entries; AW = $clog2(DEPTH).
REQ-003 Parameter NUM_SINK, default 2: number of ejection channels.
REQ-004 Parameter WIN, default 10000: watchdog window length in cycles.
REQ-005 Parameter DRAIN_CYC, default 256: idle cycles on all sinks that end DRAIN.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rstn  in  1  asynchronous, active-low reset.
REQ-008 wr_en, wr_addr[AW], wr_data[DW]  in  packet memory load port; honoured only in IDLE.
REQ-009 start  in  1  one-cycle pulse; loop  in  1  mode; num_flits  in  32  one-shot length; stop  in  1  ends loop mode.
REQ-010 data_o_src[DW], valid_o_src  out; ready_i_src  in  injection channel into the network.
REQ-011 data_i_sink[NUM_SINK*DW], valid_i_sink[NUM_SINK]  in; ready_o_sink[NUM_SINK]  out  ejection channels.
REQ-012 state_o[3], sent_cnt[32], rcv_cnt[NUM_SINK*32], rcv_xor[NUM_SINK*DW], deadlock  out  status.

Function
REQ-013 FSM states: IDLE, RUN, DRAIN, DONE, DEADLOCK.
REQ-014 IDLE->RUN on start; clears addr, sent_cnt, rcv_cnt, rcv_xor and the watchdog; start is ignored outside IDLE and DONE.
REQ-015 DONE->RUN on start, with the same clearing as REQ-014.
REQ-016 In RUN, valid_o_src = 1 and data_o_src = mem[addr]; the memory read is combinational or prefetched so the first valid appears within 2 cycles of start.
REQ-017 Once asserted, valid_o_src and data_o_src stay stable until ready_i_src is sampled high.
REQ-018 A flit is accepted when valid_o_src & ready_i_src; on acceptance addr increments, wrapping DEPTH-1->0, and sent_cnt increments.
REQ-019 One-shot mode (loop=0): after the acceptance making sent_cnt == num_flits, valid_o_src drops the next cycle and the FSM enters DRAIN.
REQ-020 One-shot with num_flits == 0: the FSM goes RUN->DRAIN with no valid asserted.
REQ-021 Loop mode: stop is latched; the FSM enters DRAIN after the next acceptance, or immediately if valid_o_src is low.
REQ-022 ready_o_sink[i] = 1 in RUN and DRAIN, 0 otherwise.
REQ-023 On each sink acceptance: rcv_cnt[i] += 1, saturating at 2^32-1; rcv_xor[i] ^= flit.
REQ-024 All sinks accepting in the same cycle are each counted.
REQ-025 DRAIN: an idle counter resets on any sink acceptance; after DRAIN_CYC consecutive idle cycles the FSM enters DONE.
REQ-026 Watchdog in RUN: a window counter runs 0..WIN-1; at count 0 it samples sent_cnt.
REQ-027 At count WIN-1, if sent_cnt equals the sample and valid_o_src=1, the FSM enters DEADLOCK and deadlock is set.
REQ-028 DEADLOCK and deadlock are sticky until reset; valid_o_src=0 and ready_o_sink=0 there.
REQ-029 Memory writes outside IDLE are dropped.
REQ-030 Outputs are registered except data_o_src.

Reset
REQ-031 On rstn low, asynchronously: state=IDLE, valid_o_src=0, ready_o_sink=0, deadlock=0, all counters, rcv_xor, addr and the stop latch =0.
REQ-032 Packet memory contents are not reset.
REQ-033 Reset asserted mid-transfer aborts it; after release the FSM waits in IDLE for start.

Structure
REQ-034 The shared package noc_params_pkg holds the FSM state enum, the DW default and the status encoding for state_o.
REQ-035 The watchdog is the sub-module progress_watchdog (params WIN, width 32; inputs en, progress count, stalled; output trip).
REQ-036 Packet memory is an inferred synchronous-write array of DEPTH x DW.

Verification
REQ-037 Load 8 flits, loop=0, num_flits=8, ready_i_src=1 -> 8 acceptances at addr 0..7, then DRAIN, then DONE after DRAIN_CYC idle cycles; sent_cnt=8.
REQ-038 Same stimulus with ready_i_src toggling every cycle -> data_o_src is stable while stalled; the accepted sequence is identical.
REQ-039 DEPTH=16, loop=1, stop after 40 acceptances -> addr wraps 15->0 twice; sent_cnt=40 (+1 if a flit was pending when stop was latched).
REQ-040 ready_i_src held 0 for >2*WIN cycles in RUN -> deadlock=1 within 2*WIN cycles; state DEADLOCK persists until rstn.
REQ-041 Sink 0 and sink 1 both valid on the same cycles with flits 0xA5 and 0x5A -> each rcv_cnt += 1 per cycle; rcv_xor reflects the flits per sink.
REQ-042 rstn pulsed low at flit 3 of 8 -> outputs go to reset values immediately; a new start restarts from addr 0.
